// File: rtl/expo_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : expo_bcd_display
// Purpose  : Converts the 2.16 fixed-point exponential result to BCD (truncated)
//            and shows it on a multiplexed, active-low 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module expo_bcd_display #(
    parameter int FRAC_DIGITS = 4,
    parameter int SCAN_DIV    = 150000
) (
    input  logic                       Ref_Clk,
    input  logic                       rst,
    input  logic                       done_expo,
    input  logic [1:0]                 intpart,
    input  logic [15:0]                fracpart,
    output logic [3:0]                 bcd_int,
    output logic [4*FRAC_DIGITS-1:0]   bcd_frac,
    output logic                       bcd_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [FRAC_DIGITS:0]       anode
);

    localparam int FW = 4 * FRAC_DIGITS;
    localparam int AW = FRAC_DIGITS + 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(FRAC_DIGITS + 1);

    localparam logic [CW-1:0] C_SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] C_IDX_LAST  = IW'(FRAC_DIGITS);
    localparam logic [2:0]    C_DIG_LAST  = 3'(FRAC_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic [1:0]      int_q, int_d;
    logic [15:0]     frac_q, frac_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic [2:0]      dcnt_q, dcnt_d;
    logic [3:0]      bcd_int_q, bcd_int_d;
    logic [FW-1:0]   bcd_frac_q, bcd_frac_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;

    logic [CW-1:0]   scan_q, scan_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [AW-1:0]   anode_q, anode_d;

    logic            w_rise;
    logic [19:0]     w_prod;
    logic [3:0]      w_digit;
    logic [FW-1:0]   w_shift_next;
    logic [3:0]      w_sel_digit;

    assign w_rise  = done_expo & ~done_q;
    // F*10 as (F<<3)+(F<<1); the overflow above bit 15 is the next decimal digit.
    assign w_prod  = {1'b0, frac_q, 3'b000} + {3'b000, frac_q, 1'b0};
    assign w_digit = w_prod[19:16];

    generate
        if (FRAC_DIGITS == 1) begin : g_shift_single
            assign w_shift_next = w_digit;
        end else begin : g_shift_multi
            assign w_shift_next = {shift_q[FW-5:0], w_digit};
        end
    endgenerate

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        done_d     = done_expo;
        int_d      = int_q;
        frac_d     = frac_q;
        shift_d    = shift_q;
        dcnt_d     = dcnt_q;
        bcd_int_d  = bcd_int_q;
        bcd_frac_d = bcd_frac_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        overrun_d  = overrun_q;

        // A rise is never queued: while busy it only flags the loss.
        if (w_rise && busy_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    int_d     = intpart;
                    frac_d    = fracpart;
                    shift_d   = '0;
                    dcnt_d    = '0;
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                frac_d  = w_prod[15:0];
                shift_d = w_shift_next;
                dcnt_d  = dcnt_q + 3'd1;
                if (dcnt_q == C_DIG_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_int_d  = {2'b00, int_q};
                bcd_frac_d = shift_q;
                valid_d    = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_sel_digit = bcd_int_q;
        for (int j = 1; j <= FRAC_DIGITS; j++) begin
            if (idx_q == IW'(j)) begin
                w_sel_digit = bcd_frac_q[4*(FRAC_DIGITS-j) +: 4];
            end
        end
    end

    always_comb begin
        scan_d = scan_q + CW'(1);
        idx_d  = idx_q;
        if (scan_q == C_SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == C_IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        seg_d   = seg_decode(w_sel_digit);
        dp_d    = (idx_q != '0);
        anode_d = ~(AW'(1) << idx_q);
    end

    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            int_q      <= '0;
            frac_q     <= '0;
            shift_q    <= '0;
            dcnt_q     <= '0;
            bcd_int_q  <= '0;
            bcd_frac_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            int_q      <= int_d;
            frac_q     <= frac_d;
            shift_q    <= shift_d;
            dcnt_q     <= dcnt_d;
            bcd_int_q  <= bcd_int_d;
            bcd_frac_q <= bcd_frac_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b1000000;
            dp_q    <= 1'b0;
            anode_q <= ~AW'(1);
        end else begin
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            anode_q <= anode_d;
        end
    end

    assign bcd_int   = bcd_int_q;
    assign bcd_frac  = bcd_frac_q;
    assign bcd_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign anode     = anode_q;

endmodule
`default_nettype wire

// File: tb/tb_expo_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_expo_bcd_display
// Purpose  : Self-checking bench for expo_bcd_display (FRAC_DIGITS=4, SCAN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_expo_bcd_display;

    localparam int FD = 4;
    localparam int SD = 4;

    logic        Ref_Clk   = 1'b0;
    logic        rst       = 1'b0;
    logic        done_expo = 1'b0;
    logic [1:0]  intpart   = 2'd0;
    logic [15:0] fracpart  = 16'd0;
    logic [3:0]  bcd_int;
    logic [15:0] bcd_frac;
    logic        bcd_valid;
    logic        busy;
    logic        overrun;
    logic [6:0]  seg;
    logic        dp;
    logic [4:0]  anode;

    expo_bcd_display #(.FRAC_DIGITS(FD), .SCAN_DIV(SD)) dut (
        .Ref_Clk   (Ref_Clk),
        .rst       (rst),
        .done_expo (done_expo),
        .intpart   (intpart),
        .fracpart  (fracpart),
        .bcd_int   (bcd_int),
        .bcd_frac  (bcd_frac),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .overrun   (overrun),
        .seg       (seg),
        .dp        (dp),
        .anode     (anode)
    );

    always #5 Ref_Clk = ~Ref_Clk;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    // Clock edges since reset release, used to place the display scan in time.
    always @(posedge Ref_Clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    typedef struct {
        logic [1:0]  ip;
        logic [15:0] fp;
        logic [3:0]  ei;
        logic [15:0] ef;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Decimal expansion of F/65536 truncated to four digits, packed as BCD.
    function automatic logic [15:0] model_frac(input logic [15:0] f);
        longint unsigned v;
        v = (longint'(f) * 10000) / 65536;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    task automatic run_conv(input logic [1:0] ip, input logic [15:0] fp,
                            output int valid_at, output int valid_cnt, output int busy_cnt,
                            output logic [3:0] got_int, output logic [15:0] got_frac,
                            output logic ov0);
        @(negedge Ref_Clk);
        intpart = ip; fracpart = fp; done_expo = 1'b1;
        @(posedge Ref_Clk);
        valid_at = -1; valid_cnt = 0; busy_cnt = 0;
        got_int = 4'h0; got_frac = 16'h0; ov0 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Ref_Clk);
            if (c == 0) ov0 = overrun;
            if (busy) busy_cnt++;
            if (bcd_valid) begin
                valid_cnt++;
                if (valid_at < 0) valid_at = c;
                got_int = bcd_int; got_frac = bcd_frac;
            end
            if (c == 3) done_expo = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " bcd_int"},   32'(bcd_int),   32'h0);
        check({tag, " bcd_frac"},  32'(bcd_frac),  32'h0);
        check({tag, " bcd_valid"}, 32'(bcd_valid), 32'h0);
        check({tag, " busy"},      32'(busy),      32'h0);
        check({tag, " overrun"},   32'(overrun),   32'h0);
        check({tag, " anode"},     32'(anode),     32'h1E);
        check({tag, " seg"},       32'(seg),       32'h40);
        check({tag, " dp"},        32'(dp),        32'h0);
    endtask

    initial begin
        int va, vc, bc, cnt;
        logic [3:0]  gi;
        logic [15:0] gf, mf;
        logic        ov;
        logic [3:0]  digs [5];
        int          idx, m;
        logic [1:0]  rip;
        logic [15:0] rfp;

        vecs[0] = '{ip: 2'd2, fp: 16'hB7E1, ei: 4'h2, ef: 16'h7182};
        vecs[1] = '{ip: 2'd3, fp: 16'hFFFF, ei: 4'h3, ef: 16'h9999};
        vecs[2] = '{ip: 2'd0, fp: 16'h8000, ei: 4'h0, ef: 16'h5000};
        vecs[3] = '{ip: 2'd1, fp: 16'h0000, ei: 4'h1, ef: 16'h0000};

        #12;
        check_reset_state("reset");
        @(negedge Ref_Clk); rst = 1'b1;
        repeat (3) @(negedge Ref_Clk);

        // Table-driven conversions with latency/busy checks
        for (int i = 0; i < 4; i++) begin
            run_conv(vecs[i].ip, vecs[i].fp, va, vc, bc, gi, gf, ov);
            check($sformatf("vec%0d valid_latency", i), 32'(va), 32'd5);
            check($sformatf("vec%0d valid_pulses", i),  32'(vc), 32'd1);
            check($sformatf("vec%0d busy_cycles", i),   32'(bc), 32'd5);
            check($sformatf("vec%0d bcd_int", i),       32'(gi), 32'(vecs[i].ei));
            check($sformatf("vec%0d bcd_frac", i),      32'(gf), 32'(vecs[i].ef));
            check($sformatf("vec%0d held_frac", i),     32'(bcd_frac), 32'(vecs[i].ef));
        end

        // done_expo held high for 20 cycles: one conversion only
        @(negedge Ref_Clk);
        intpart = 2'd1; fracpart = 16'h4000; done_expo = 1'b1;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge Ref_Clk);
            if (bcd_valid) cnt++;
            if (c == 19) done_expo = 1'b0;
        end
        check("held_high pulses", 32'(cnt), 32'd1);
        check("held_high frac",   32'(bcd_frac), 32'h2500);

        // Second rise two cycles after capture: overrun, first value kept
        @(negedge Ref_Clk);
        intpart = 2'd2; fracpart = 16'hB7E1; done_expo = 1'b1;
        @(posedge Ref_Clk);
        @(negedge Ref_Clk); done_expo = 1'b0; intpart = 2'd1; fracpart = 16'h1234;
        @(negedge Ref_Clk); done_expo = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Ref_Clk);
            if (bcd_valid) cnt++;
            if (c == 6) done_expo = 1'b0;
        end
        check("overrun flag",   32'(overrun),  32'h1);
        check("overrun pulses", 32'(cnt),      32'd1);
        check("overrun int",    32'(bcd_int),  32'h2);
        check("overrun frac",   32'(bcd_frac), 32'h7182);
        run_conv(2'd3, 16'h8000, va, vc, bc, gi, gf, ov);
        check("overrun cleared", 32'(ov), 32'h0);
        check("after_ovr frac",  32'(gf), 32'h5000);

        // Rise landing on the DONE cycle counts as overrun, not queued
        @(negedge Ref_Clk);
        intpart = 2'd0; fracpart = 16'h1000; done_expo = 1'b1;
        @(posedge Ref_Clk);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Ref_Clk);
            if (bcd_valid) cnt++;
            if (c == 0) done_expo = 1'b0;
            if (c == 4) done_expo = 1'b1;
            if (c == 9) done_expo = 1'b0;
        end
        check("done_rise pulses",  32'(cnt),      32'd1);
        check("done_rise overrun", 32'(overrun),  32'h1);
        check("done_rise frac",    32'(bcd_frac), 32'h0625);

        // Display scan on 2.7182
        run_conv(2'd2, 16'hB7E1, va, vc, bc, gi, gf, ov);
        check("disp overrun cleared", 32'(ov), 32'h0);
        mf = model_frac(16'hB7E1);
        digs[0] = 4'd2;
        for (int j = 1; j <= 4; j++) digs[j] = mf[4*(4-j) +: 4];
        for (int c = 0; c < 25; c++) begin
            @(negedge Ref_Clk);
            m   = edges;
            idx = ((m - 1) / SD) % (FD + 1);
            check($sformatf("scan%0d anode", c), 32'(anode), 32'(~(5'b00001 << idx) & 5'h1F));
            check($sformatf("scan%0d seg", c),   32'(seg),   32'(glyph(digs[idx])));
            check($sformatf("scan%0d dp", c),    32'(dp),    (idx == 0) ? 32'h0 : 32'h1);
        end

        // Asynchronous reset two cycles after a capture
        @(negedge Ref_Clk);
        intpart = 2'd1; fracpart = 16'hFFFF; done_expo = 1'b1;
        @(posedge Ref_Clk);
        @(negedge Ref_Clk); done_expo = 1'b0;
        @(posedge Ref_Clk);
        @(posedge Ref_Clk);
        #2 rst = 1'b0;
        #1 check_reset_state("midreset");
        cnt = 0;
        repeat (2) begin @(negedge Ref_Clk); if (bcd_valid) cnt++; end
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin @(negedge Ref_Clk); if (bcd_valid) cnt++; end
        check("midreset no_valid", 32'(cnt), 32'd0);
        check("midreset frac_held", 32'(bcd_frac), 32'h0);
        run_conv(2'd1, 16'hFFFF, va, vc, bc, gi, gf, ov);
        check("post_reset int",  32'(gi), 32'h1);
        check("post_reset frac", 32'(gf), 32'h9999);

        // Reset released while done_expo already high
        @(negedge Ref_Clk);
        rst = 1'b0; done_expo = 1'b1; intpart = 2'd3; fracpart = 16'h8000;
        @(negedge Ref_Clk); rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Ref_Clk);
            if (bcd_valid) cnt++;
            if (c == 8) done_expo = 1'b0;
        end
        check("release_high pulses", 32'(cnt),      32'd1);
        check("release_high int",    32'(bcd_int),  32'h3);
        check("release_high frac",   32'(bcd_frac), 32'h5000);

        // Randomized conversions against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            rip = 2'($urandom_range(0, 3));
            rfp = 16'($urandom);
            run_conv(rip, rfp, va, vc, bc, gi, gf, ov);
            check($sformatf("rand%0d latency", i), 32'(va), 32'd5);
            check($sformatf("rand%0d int", i),     32'(gi), 32'({2'b00, rip}));
            check($sformatf("rand%0d frac", i),    32'(gf), 32'(model_frac(rfp)));
            repeat ($urandom_range(0, 3)) @(negedge Ref_Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/expo_bcd_display.md
Name: expo_bcd_display

Overview:
- Downstream consumer of the exponential accelerator's 2.16 fixed-point result (`intpart`, `fracpart`, `done_expo`).
- Converts each new result to decimal by iterative ×10 on the fraction: 1 integer digit plus FRAC_DIGITS fraction digits.
- Holds the last converted value and drives a multiplexed, active-low 7-segment display. The decimal point is lit on the integer digit.

Parameters:
- FRAC_DIGITS, 4: number of fractional decimal digits produced and displayed (1..4).
- SCAN_DIV, 150000: Ref_Clk cycles per display digit slot (1 kHz at 150 MHz).

Ports:
- Ref_Clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- done_expo  in  1  result-ready level from the accelerator; only its rising edge is used.
- intpart  in  2  integer part of result.
- fracpart  in  16  fractional part, unsigned, weight 2^-16.
- bcd_int  out  4  held integer digit.
- bcd_frac  out  4*FRAC_DIGITS  held fraction digits; most significant digit in the top nibble.
- bcd_valid  out  1  one-cycle pulse when bcd_int/bcd_frac update.
- busy  out  1  high while capture/conversion is in progress.
- overrun  out  1  sticky; a done_expo rising edge arrived while busy.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- anode  out  FRAC_DIGITS+1  digit select, one-hot, active-low; bit 0 is the integer digit.

Behaviour:
- Reset (rst=0, async):
  - FSM → IDLE; bcd_int=0, bcd_frac=0, bcd_valid=0, busy=0, overrun=0.
  - Scan counter and digit index cleared; anode=~1 (integer digit selected), seg=7'b1000000 ("0"), dp=0.
  - The edge-detect register clears to 0, so a done_expo already high when reset releases counts as a rising edge.
- Edge detect: register done_expo. rise = done_expo & ~done_q.
- FSM IDLE:
  - On rise at edge k: latch I=intpart, F=fracpart, clear the digit shift register and cycle count.
  - Set busy=1 and go to CONV. Also clear overrun on this accepted capture.
- FSM CONV, one digit per cycle:
  - P = (F<<3) + (F<<1), 20-bit; digit = P[19:16] (always 0..9); F ← P[15:0].
  - Shift digit into the low nibble of the shift register.
  - After FRAC_DIGITS cycles go to DONE.
  - Result is truncated, not rounded.
- FSM DONE:
  - Load bcd_int = {2'b00, I} and bcd_frac = shift register; pulse bcd_valid.
  - Clear busy; return to IDLE.
- Latency:
  - Capture at edge k; bcd_int, bcd_frac and bcd_valid are registered at edge k+FRAC_DIGITS+1.
  - bcd_valid is high for exactly that one cycle; busy is high from k through k+FRAC_DIGITS.
- Rise while busy:
  - Ignored; the in-flight conversion completes with the originally latched value.
  - overrun ← 1 and stays high until reset or the next accepted capture.
- Rise in the same cycle DONE executes: busy is still 1, so the rise counts as overrun (not queued).
- done_expo held high: only one conversion; another requires a low-then-high transition.
- Held outputs: unchanged between bcd_valid pulses; the display always reflects them.
- Display scan:
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0,1..FRAC_DIGITS and wraps back to 0.
  - Index 0 shows bcd_int with dp=0 (lit); index j≥1 shows fraction digit j, most significant first, with dp=1.
  - seg and anode are registered from the index and held digits, so they change one cycle after the index.
  - Decode is standard 0–9; any digit >9 decodes to blank (7'h7F). Scanning runs regardless of FSM state.
- Reset mid-conversion: conversion discarded, outputs return to reset values, no bcd_valid.

Test Plan:
- Reset, then intpart=2, fracpart=16'hB7E1, single done_expo rise → bcd_valid pulse exactly 5 cycles after the capture edge (FRAC_DIGITS=4); bcd_int=4'h2, bcd_frac=16'h7182; busy high 5 cycles.
- intpart=3, fracpart=16'hFFFF → bcd_int=3, bcd_frac=16'h9999 (truncation). Then intpart=0, fracpart=16'h8000 → bcd_frac=16'h5000; intpart=1, fracpart=0 → 1.0000.
- done_expo held high 20 cycles → exactly one bcd_valid pulse. Second rise 2 cycles after the first capture → overrun=1, result still from the first value. Next accepted capture clears overrun.
- SCAN_DIV=4 override, result 2.7182 → anode sequence 11110,11101,11011,10111,01111 repeating every 4 cycles. seg = "2" with dp=0, then "7","1","8","2" with dp=1.
- rst asserted low 2 cycles after a capture → busy=0, bcd_int/bcd_frac=0 immediately (async), no bcd_valid. A rise after release converts normally.
- rst released with done_expo already high → one conversion triggered from the edge detector's reset state.
